// File: rtl/matrix_loader.sv
// matrix_loader: assembles a row-major word stream into an N x N buffer and,
// once a full frame is held, asserts timer_en for FEED_LEN cycles so the
// downstream matrix_timer can skew the buffer out.
module matrix_loader #(
  parameter int N        = 32,
  parameter int DW       = 16,
  parameter int FEED_LEN = 2*N-1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DW-1:0]                 in_data,
  input  logic                          in_last,
  output logic [0:N-1][0:N-1][DW-1:0]   matrix_out,
  output logic                          timer_en,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          err_len
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = $clog2(FEED_LEN + 1);

  typedef enum logic {LOAD, FEED} state_t;

  state_t                        state_q, state_d;
  logic [IW-1:0]                 row_q, row_d;
  logic [IW-1:0]                 col_q, col_d;
  logic [FW-1:0]                 feed_q, feed_d;
  logic                          done_q, done_d;
  logic                          err_q, err_d;
  logic                          wr_en;
  logic                          accept;
  logic                          at_end;
  logic [0:N-1][0:N-1][DW-1:0]   mat_q;

  // in_ready depends on state only, so there is no in_valid -> in_ready path.
  assign in_ready   = (state_q == LOAD);
  assign timer_en   = (state_q == FEED);
  assign busy       = (state_q == FEED);
  assign frame_done = done_q;
  assign err_len    = err_q;
  assign matrix_out = mat_q;
  assign accept     = in_valid && in_ready;
  assign at_end     = (row_q == IW'(N-1)) && (col_q == IW'(N-1));

  // Next-state logic: write-position tracking, frame/error detection, feed count.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    feed_d  = feed_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (at_end || in_last) begin
            // Any frame boundary, good or bad, restarts writing at [0][0].
            row_d = '0;
            col_d = '0;
            if (at_end && in_last) begin
              state_d = FEED;
              feed_d  = '0;
            end else begin
              err_d = 1'b1;
            end
          end else if (col_q == IW'(N-1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      FEED: begin
        if (feed_q == FW'(FEED_LEN-1)) begin
          state_d = LOAD;
          done_d  = 1'b1;
          row_d   = '0;
          col_d   = '0;
        end else begin
          feed_d = feed_q + 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      row_q   <= '0;
      col_q   <= '0;
      feed_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      feed_q  <= feed_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Matrix buffer: cleared on reset, written only on an accepted word in LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      mat_q <= '0;
    end else if (wr_en) begin
      mat_q[row_q][col_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: a queue holds the expected outcome
// (feed or framing error) of each driven frame, popped when the DUT reacts.
module tb_matrix_loader;

  localparam int N        = 32;
  localparam int DW       = 16;
  localparam int FEED_LEN = 2*N-1;
  localparam int NW       = N*N;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        in_valid;
  logic                        in_ready;
  logic [DW-1:0]               in_data;
  logic                        in_last;
  logic [0:N-1][0:N-1][DW-1:0] matrix_out;
  logic                        timer_en;
  logic                        busy;
  logic                        frame_done;
  logic                        err_len;

  always #5 clk = ~clk;

  matrix_loader #(.N(N), .DW(DW), .FEED_LEN(FEED_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .matrix_out (matrix_out),
    .timer_en   (timer_en),
    .busy       (busy),
    .frame_done (frame_done),
    .err_len    (err_len)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int exp_mat [N][N];
  bit exp_q [$];        // 1 = framing error expected, 0 = feed expected
  int run       = 0;
  bit prev_en   = 1'b0;
  bit prev_err  = 1'b0;
  bit abort_run = 1'b0;
  bit mon_on    = 1'b0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int mat_diffs(input bit zero);
    int d = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (int'(matrix_out[i][j]) != (zero ? 0 : exp_mat[i][j])) d++;
    return d;
  endfunction

  // Output monitor: pops the scoreboard on feed start / error pulse.
  always @(negedge clk) begin
    if (mon_on) begin
      if (timer_en && !prev_en) begin
        if (exp_q.size() == 0) check_eq("unexpected_feed", 1, 0);
        else check_eq("feed_kind", exp_q.pop_front(), 0);
        check_eq("ready_in_feed", in_ready, 0);
        check_eq("busy_in_feed", busy, 1);
        check_eq("matrix_at_feed", mat_diffs(1'b0), 0);
        check_eq("m00", matrix_out[0][0], exp_mat[0][0]);
        check_eq("m0_last", matrix_out[0][N-1], exp_mat[0][N-1]);
        check_eq("mlast_last", matrix_out[N-1][N-1], exp_mat[N-1][N-1]);
        run = 1;
      end else if (timer_en) begin
        run++;
      end
      if (!timer_en && prev_en) begin
        if (!abort_run) begin
          check_eq("feed_len", run, FEED_LEN);
          check_eq("done_pulse", frame_done, 1);
          check_eq("matrix_at_end", mat_diffs(1'b0), 0);
          check_eq("ready_after_feed", in_ready, 1);
        end else begin
          check_eq("no_done_after_rst", frame_done, 0);
        end
        abort_run = 1'b0;
      end else if (frame_done) begin
        check_eq("spurious_done", 1, 0);
      end
      if (err_len) begin
        if (exp_q.size() == 0) check_eq("unexpected_err", 1, 0);
        else check_eq("err_kind", exp_q.pop_front(), 1);
        check_eq("err_no_en", timer_en, 0);
        check_eq("err_no_done", frame_done, 0);
        if (prev_err) check_eq("err_width", 2, 1);
      end
      prev_en  = timer_en;
      prev_err = err_len;
    end
  end

  task automatic send_word(input logic [DW-1:0] d, input logic l, input bit bubble);
    bit done = 1'b0;
    bit rdy;
    int guard = 0;
    while (!done) begin
      in_data  = d;
      in_last  = l;
      in_valid = bubble ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (in_valid && rdy) done = 1'b1;
      guard++;
      if (!done && guard > 1000) begin
        check_eq("accept_timeout", 0, 1);
        done = 1'b1;
      end
    end
  endtask

  task automatic drive_frame(input int nwords, input int last_idx, input bit bubble,
                             input bit pat2, input bit hold_valid, input int rst_at);
    bit is_err;
    logic [DW-1:0] v;
    is_err = !(nwords == NW && last_idx == NW-1);
    exp_q.push_back(is_err);
    for (int k = 0; k < nwords; k++) begin
      v = pat2 ? DW'(2048 - k) : DW'(k + 1);
      send_word(v, (k == last_idx), bubble);
      exp_mat[k/N][k%N] = int'(v);
    end
    in_valid = hold_valid;
    in_data  = 16'hDEAD;
    in_last  = 1'b0;
    @(negedge clk);
    if (is_err) begin
      check_eq("err_next", err_len, 1);
      check_eq("en_on_err", timer_en, 0);
    end else begin
      check_eq("en_next", timer_en, 1);
      check_eq("ready_next", in_ready, 0);
    end
    if (hold_valid) begin
      repeat (FEED_LEN-2) @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    if (rst_at > 0) begin
      for (int g = 0; g < 200; g++) begin
        @(negedge clk);
        #1;
        if (run >= rst_at) break;
      end
      @(posedge clk);
      #1;
      rst       = 1'b1;
      abort_run = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_en", timer_en, 0);
      check_eq("rst_ready", in_ready, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", frame_done, 0);
      check_eq("rst_matrix", mat_diffs(1'b1), 0);
    end
    for (int g = 0; g < FEED_LEN + 10; g++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check_eq("idle_reached", busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        exp_mat[i][j] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_ready", in_ready, 1);
    check_eq("reset_en", timer_en, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", frame_done, 0);
    check_eq("reset_err", err_len, 0);
    check_eq("reset_matrix", mat_diffs(1'b1), 0);
    mon_on = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back frame, then bubbled copy, then second pattern.
    drive_frame(NW, NW-1, 1'b0, 1'b0, 1'b0, 0);
    drive_frame(NW, NW-1, 1'b1, 1'b0, 1'b0, 0);
    drive_frame(NW, NW-1, 1'b0, 1'b1, 1'b0, 0);
    // Early in_last on word 500, then a full frame.
    drive_frame(500, 499, 1'b0, 1'b0, 1'b0, 0);
    drive_frame(NW, NW-1, 1'b0, 1'b0, 1'b0, 0);
    // Missing in_last, then a frame with in_valid held through FEED.
    drive_frame(NW, -1, 1'b0, 1'b0, 1'b0, 0);
    drive_frame(NW, NW-1, 1'b0, 1'b1, 1'b1, 0);
    // Reset in FEED cycle 30, then a bubbled frame.
    drive_frame(NW, NW-1, 1'b0, 1'b0, 1'b0, 30);
    drive_frame(NW, NW-1, 1'b1, 1'b1, 1'b0, 0);

    repeat (3) @(negedge clk);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
